// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the SimpleRISC branch predict unit.
// Purpose : 2-bit counter encodings, the sequential PC step, the table
//           command type and the PC index/tag slicing helpers.
// Ports   : none (package).
package branch_predict_unit_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        TBL_NOP   = 2'd0,
        TBL_TRAIN = 2'd1,
        TBL_INVAL = 2'd2
    } tblOp_e;

    // Helpers work on a 64-bit container so they serve any AW; callers keep
    // only the low bits they need.
    function automatic logic [63:0] pcIndex(input logic [63:0] pc, input int idxBits);
        return (pc >> 2) & ((64'd1 << idxBits) - 64'd1);
    endfunction

    function automatic logic [63:0] pcTag(input logic [63:0] pc, input int idxBits);
        return pc >> (idxBits + 2);
    endfunction

    function automatic logic [1:0] ctrInc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] ctrDec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Core <-> branch predict unit signal bundle.
// Purpose : groups the fetch lookup, ALU resolution and statistics signals.
// Ports   : master = core side (drives fetch PC and ALU-stage branch info),
//           slave  = predict unit (returns prediction, resolution, count).
interface branch_predict_unit_if #(
    parameter int AW    = 32,
    parameter int CNT_W = 16
);
    logic [AW-1:0]    pc_IF;
    logic             predTaken_IF;
    logic [AW-1:0]    predPC_IF;

    logic             valid_ALU;
    logic [AW-1:0]    pc_ALU;
    logic [AW-1:0]    immx_ALU;
    logic [AW-1:0]    A_ALU;
    logic             isUBranch_ALU;
    logic             isBeq_ALU;
    logic             isBgt_ALU;
    logic             isRet_ALU;
    logic             flagsE;
    logic             flagsGT;
    logic             predTaken_ALU;
    logic [AW-1:0]    predPC_ALU;

    logic [AW-1:0]    branchPC;
    logic             isBranchTaken;
    logic             mispredict;
    logic [AW-1:0]    redirectPC;
    logic [CNT_W-1:0] mispredictCount;

    modport master (
        output pc_IF,
        input  predTaken_IF, predPC_IF,
        output valid_ALU, pc_ALU, immx_ALU, A_ALU,
        output isUBranch_ALU, isBeq_ALU, isBgt_ALU, isRet_ALU,
        output flagsE, flagsGT, predTaken_ALU, predPC_ALU,
        input  branchPC, isBranchTaken, mispredict, redirectPC, mispredictCount
    );

    modport slave (
        input  pc_IF,
        output predTaken_IF, predPC_IF,
        input  valid_ALU, pc_ALU, immx_ALU, A_ALU,
        input  isUBranch_ALU, isBeq_ALU, isBgt_ALU, isRet_ALU,
        input  flagsE, flagsGT, predTaken_ALU, predPC_ALU,
        output branchPC, isBranchTaken, mispredict, redirectPC, mispredictCount
    );

endinterface

// File: rtl/branch_predict_unit_table.sv
// Direct-mapped BTB with 2-bit direction counters.
// Purpose : DEPTH entries of {valid, tag, target, ctr}; one combinational
//           lookup port and one training/invalidate write port.
// Ports   : clk, reset (sync, active-high: clears valid, ctr := WNT)
//           rdPc -> rdHit, rdCtr, rdTarget      (lookup, pre-edge contents)
//           wrOp, wrPc, wrTaken, wrTarget        (update on rising edge)
module branch_predict_unit_table
    import branch_predict_unit_pkg::*;
#(
    parameter int AW       = 32,
    parameter int IDX_BITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rdPc,
    output logic          rdHit,
    output logic [1:0]    rdCtr,
    output logic [AW-1:0] rdTarget,
    input  tblOp_e        wrOp,
    input  logic [AW-1:0] wrPc,
    input  logic          wrTaken,
    input  logic [AW-1:0] wrTarget
);
    localparam int DEPTH = 1 << IDX_BITS;
    localparam int TAG_W = AW - IDX_BITS - 2;

    logic                vldMem [DEPTH];
    logic [TAG_W-1:0]    tagMem [DEPTH];
    logic [AW-1:0]       tgtMem [DEPTH];
    logic [1:0]          ctrMem [DEPTH];

    logic [63:0]         rdIdxFull, rdTagFull, wrIdxFull, wrTagFull;
    logic [IDX_BITS-1:0] rdIdx, wrIdx;
    logic [TAG_W-1:0]    rdTag, wrTag;
    logic                wrHit;
    logic                unusedSliceBits;

    assign rdIdxFull = pcIndex(64'(rdPc), IDX_BITS);
    assign rdTagFull = pcTag(64'(rdPc), IDX_BITS);
    assign wrIdxFull = pcIndex(64'(wrPc), IDX_BITS);
    assign wrTagFull = pcTag(64'(wrPc), IDX_BITS);

    assign rdIdx = rdIdxFull[IDX_BITS-1:0];
    assign rdTag = rdTagFull[TAG_W-1:0];
    assign wrIdx = wrIdxFull[IDX_BITS-1:0];
    assign wrTag = wrTagFull[TAG_W-1:0];

    // Upper bits of the 64-bit helper results are zero by construction.
    assign unusedSliceBits = ^{rdIdxFull[63:IDX_BITS], rdTagFull[63:TAG_W],
                               wrIdxFull[63:IDX_BITS], wrTagFull[63:TAG_W]};

    assign rdHit    = vldMem[rdIdx] && (tagMem[rdIdx] == rdTag);
    assign rdCtr    = ctrMem[rdIdx];
    assign rdTarget = tgtMem[rdIdx];

    assign wrHit = vldMem[wrIdx] && (tagMem[wrIdx] == wrTag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vldMem[i] <= 1'b0;
                ctrMem[i] <= WNT;
            end
        end else begin
            case (wrOp)
                TBL_TRAIN: begin
                    if (wrTaken) begin
                        vldMem[wrIdx] <= 1'b1;
                        // Fresh allocation starts weakly taken rather than
                        // inheriting another branch's history.
                        ctrMem[wrIdx] <= wrHit ? ctrInc(ctrMem[wrIdx]) : WT;
                    end else begin
                        ctrMem[wrIdx] <= ctrDec(ctrMem[wrIdx]);
                    end
                end
                TBL_INVAL: vldMem[wrIdx] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Tag/target need no reset: they are only observed through valid.
    always_ff @(posedge clk) begin
        if (!reset && (wrOp == TBL_TRAIN) && wrTaken) begin
            tagMem[wrIdx] <= wrTag;
            tgtMem[wrIdx] <= wrTarget;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with fetch-side BTB prediction.
// Purpose : fetch lookup (0-cycle), ALU-stage resolution and mispredict
//           detection (0-cycle), table training on the resolving edge and a
//           saturating mispredict counter.
// Ports   : clk, reset (sync, active-high)
//           bus (slave) : pc_IF -> predTaken_IF/predPC_IF;
//                         ALU-stage branch info -> branchPC, isBranchTaken,
//                         mispredict, redirectPC; mispredictCount.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int AW       = 32,
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 16
) (
    input logic                 clk,
    input logic                 reset,
    branch_predict_unit_if.slave bus
);
    logic          tblHit;
    logic [1:0]    tblCtr;
    logic [AW-1:0] tblTarget;
    tblOp_e        tblOp;

    logic          predTaken;
    logic          isBr;
    logic          isTrainable;
    logic          taken;
    logic [AW-1:0] target;
    logic          misp;
    logic [CNT_W-1:0] mispCount;

    branch_predict_unit_table #(
        .AW       (AW),
        .IDX_BITS (IDX_BITS)
    ) uTable (
        .clk      (clk),
        .reset    (reset),
        .rdPc     (bus.pc_IF),
        .rdHit    (tblHit),
        .rdCtr    (tblCtr),
        .rdTarget (tblTarget),
        .wrOp     (tblOp),
        .wrPc     (bus.pc_ALU),
        .wrTaken  (taken),
        .wrTarget (target)
    );

    assign predTaken        = tblHit & tblCtr[1];
    assign bus.predTaken_IF = predTaken;
    assign bus.predPC_IF    = predTaken ? tblTarget : bus.pc_IF + AW'(PC_STEP);

    assign isBr        = bus.isUBranch_ALU | bus.isBeq_ALU | bus.isBgt_ALU | bus.isRet_ALU;
    assign isTrainable = (bus.isUBranch_ALU | bus.isBeq_ALU | bus.isBgt_ALU) & ~bus.isRet_ALU;

    assign target = bus.isRet_ALU ? bus.A_ALU : bus.pc_ALU + bus.immx_ALU;
    assign taken  = bus.valid_ALU & (bus.isUBranch_ALU | bus.isRet_ALU |
                                     (bus.isBeq_ALU & bus.flagsE) |
                                     (bus.isBgt_ALU & bus.flagsGT));

    // Covers a missed taken branch, a wrong predicted target, and any
    // predicted-taken instruction that did not branch (including aliases).
    always_comb begin
        misp = 1'b0;
        if (bus.valid_ALU && !reset) begin
            if (taken)
                misp = !bus.predTaken_ALU || (bus.predPC_ALU != target);
            else
                misp = bus.predTaken_ALU;
        end
    end

    always_comb begin
        tblOp = TBL_NOP;
        if (bus.valid_ALU && !reset) begin
            if (isTrainable)
                tblOp = TBL_TRAIN;
            else if (!isBr && bus.predTaken_ALU)
                tblOp = TBL_INVAL;
        end
    end

    assign bus.branchPC      = target;
    assign bus.isBranchTaken = taken;
    assign bus.mispredict    = misp;
    assign bus.redirectPC    = taken ? target : bus.pc_ALU + AW'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset)
            mispCount <= '0;
        else if (misp && (mispCount != '1))
            mispCount <= mispCount + 1'b1;
    end

    assign bus.mispredictCount = mispCount;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Execute-stage branch resolution unit, extended with a fetch-side direction/target predictor for the pipelined SimpleRISC core.
- Fetch stage looks up a direct-mapped BTB with 2-bit saturating counters.
- ALU stage resolves the branch, compares the outcome against the prediction carried down the pipe, raises mispredict with a redirect PC, and trains the tables.
- Parametrised in address width, table depth and statistics width.

Parameters:
- AW, 32, PC/immediate/operand width.
- IDX_BITS, 4, log2 of table entries (DEPTH = 2**IDX_BITS).
- CNT_W, 16, mispredict statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_IF  in  AW  fetch PC.
- predTaken_IF  out  1  predicted taken.
- predPC_IF  out  AW  predicted next PC.
- valid_ALU  in  1  ALU stage holds a real instruction (not a bubble).
- pc_ALU, immx_ALU, A_ALU  in  AW  branch PC, sign-extended offset, ret operand.
- isUBranch_ALU, isBeq_ALU, isBgt_ALU, isRet_ALU  in  1  branch type; at most one high.
- flagsE, flagsGT  in  1  flags.
- predTaken_ALU  in  1  prediction carried from fetch.
- predPC_ALU  in  AW  prediction carried from fetch.
- branchPC  out  AW  resolved target.
- isBranchTaken  out  1  resolved direction.
- mispredict  out  1  flush IF/ID and redirect.
- redirectPC  out  AW  correct next PC.
- mispredictCount  out  CNT_W  saturating mispredict total.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[AW-1:IDX_BITS+2].
- Each entry holds: valid, tag, target[AW], ctr[1:0].
- Lookup (combinational):
  - hit = valid & tag match.
  - predTaken_IF = hit & ctr[1].
  - predPC_IF = target if predTaken_IF, else pc_IF+4 (mod 2**AW).
  - A lookup on the same cycle as a write to the same index sees the pre-edge contents.
- Resolution (combinational):
  - branchPC = isRet_ALU ? A_ALU : pc_ALU+immx_ALU (mod 2**AW).
  - isBranchTaken = valid_ALU & (isUBranch | isRet | isBeq&flagsE | isBgt&flagsGT).
  - isBr = isUBranch|isBeq|isBgt|isRet.
- Mispredict = valid_ALU & !reset & one of:
  - (a) isBranchTaken & !predTaken_ALU;
  - (b) isBranchTaken & predTaken_ALU & predPC_ALU != branchPC;
  - (c) !isBranchTaken & predTaken_ALU. This includes a non-branch predicted taken through aliasing.
- redirectPC = isBranchTaken ? branchPC : pc_ALU+4.
- Training, on the edge when valid_ALU & !reset:
  - Conditional or unconditional branch, not ret: ctr saturating increment if taken, decrement if not taken (00 and 11 hold). If taken, write valid=1, tag, target=branchPC; on allocate to an invalid or tag-mismatched entry, ctr := 10.
  - Ret: tables untouched; always resolved through mispredict unless correctly predicted by chance.
  - Non-branch with predTaken_ALU: clear valid at its index.
- mispredictCount increments by 1 on each mispredict cycle and saturates at all-ones.
- Reset, synchronous: all valid := 0, all ctr := 01, mispredictCount := 0. mispredict is forced 0 while reset is high. Tables are not trained while reset is high. Reset asserted mid-stream discards the in-flight resolution.
- Pipeline stalls are expressed by the core holding valid_ALU low; there are no other handshakes.
- Latency: prediction 0 cycles, resolution 0 cycles, table update visible to lookup 1 cycle after the training edge.

Decomposition:
- Shared package holds:
  - counter encoding constants SNT=00, WNT=01, WT=10, ST=11;
  - PC_STEP=4;
  - the index/tag slicing function.
- Sub-module bpu_table: DEPTH-entry storage with one combinational read port, one write port and synchronous reset of valid/ctr.
- The top level holds resolution, the mispredict compare and the statistics counter.

Test Plan:
- Reset, then pc_IF=0x100 -> predTaken_IF=0, predPC_IF=0x104, mispredictCount=0.
- Beq at 0x100, immx=0x20, flagsE=1, predTaken_ALU=0 -> mispredict=1, redirectPC=0x120, entry ctr=10. Next cycle, pc_IF=0x100 -> predTaken_IF=1, predPC_IF=0x120.
- Same beq executed taken 3 more times, then flagsE=0 with predTaken_ALU=1 -> mispredict=1, redirectPC=0x104, ctr 11->10, predTaken_IF still 1.
- Ret with A_ALU=0x400, predTaken_ALU=1, predPC_ALU=0x400 -> mispredict=0, isBranchTaken=1, tables unchanged.
- Aliasing: non-branch at 0x100+(DEPTH*4) with predTaken_ALU=1 -> mispredict=1, redirectPC=pc+4, entry invalidated. A later lookup of 0x100 -> predTaken_IF=0.
- Force 2**CNT_W+5 mispredicts with CNT_W=4 -> mispredictCount holds 0xF. Assert reset mid-sequence -> count 0 and all predictions not-taken the next cycle.
